// File: rtl/box_muller_pkg.sv
// Shared types and sizing helpers for the Box-Muller sequencer and its output FIFO.
package box_muller_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } bm_state_e;

  localparam int DEF_PIPE_LAT   = 3;
  localparam int DEF_FIFO_DEPTH = 8;

  // Pointer width indexes the entries; count width must also represent "full".
  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  localparam int DEF_PTR_W = ptr_w(DEF_FIFO_DEPTH);
  localparam int DEF_CNT_W = cnt_w(DEF_FIFO_DEPTH);

endpackage

// File: rtl/bm_out_fifo.sv
// First-word fall-through FIFO holding sin/cos sample pairs for the consumer.
module bm_out_fifo
  import box_muller_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int DEPTH = DEF_FIFO_DEPTH,
  localparam int AW = ptr_w(DEPTH),
  localparam int CW = cnt_w(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             valid,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  // A pop on an empty FIFO is dropped; a push into a full FIFO only lands if a pop frees the slot.
  assign do_pop  = pop && (count != '0);
  assign do_push = push && ((count != CW'(DEPTH)) || do_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

  // Head is masked while empty so stale entries never appear after reset.
  assign valid   = (count != '0);
  assign rd_data = valid ? mem[rd_ptr] : '0;

endmodule

// File: rtl/box_muller_ctrl.sv
// Issue sequencer for the Box-Muller datapath: credit-gated generator advance, latency tracking, output buffering.
module box_muller_ctrl
  import box_muller_pkg::*;
#(
  parameter int OUT        = 32,
  parameter int PIPE_LAT   = DEF_PIPE_LAT,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] n_pairs,
  input  logic             stop,
  output logic             urng_en,
  output logic             rom_re,
  input  logic [OUT-1:0]   x1_in,
  input  logic [OUT-1:0]   x2_in,
  output logic [OUT-1:0]   out1,
  output logic [OUT-1:0]   out2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic             done
);

  localparam int FCW = cnt_w(FIFO_DEPTH);

  bm_state_e        state;
  logic [PIPE_LAT:1] vld;
  logic [CNT_W-1:0] remaining;
  logic             continuous;
  logic [FCW-1:0]   fifo_count;
  logic [FCW:0]     inflight;
  logic             credit_ok;
  logic             issue;

  always_comb begin
    inflight = '0;
    for (int i = 1; i <= PIPE_LAT; i++) inflight = inflight + (FCW + 1)'(vld[i]);
  end

  // Credit counts samples still in the pipe; a same-cycle pop is deliberately not credited.
  assign credit_ok = (({1'b0, fifo_count} + inflight) < (FCW + 1)'(FIFO_DEPTH));
  assign issue     = (state == ST_RUN) && !stop && credit_ok && (continuous || (remaining != '0));

  assign urng_en = issue;
  assign rom_re  = vld[1];
  assign busy    = (state != ST_IDLE);
  assign done    = (state == ST_DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      vld        <= '0;
      remaining  <= '0;
      continuous <= 1'b0;
    end else begin
      vld[1] <= issue;
      for (int i = 2; i <= PIPE_LAT; i++) vld[i] <= vld[i-1];
      if (issue && !continuous) remaining <= remaining - 1'b1;

      case (state)
        ST_IDLE: begin
          if (start) begin
            state      <= ST_RUN;
            remaining  <= n_pairs;
            continuous <= (n_pairs == '0);
          end
        end
        ST_RUN: begin
          if (stop)
            state <= ST_DRAIN;
          else if (issue && !continuous && (remaining == CNT_W'(1)))
            state <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if ((inflight == '0) && (fifo_count == '0)) state <= ST_DONE;
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  bm_out_fifo #(
    .WIDTH (2 * OUT),
    .DEPTH (FIFO_DEPTH)
  ) u_out_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (vld[PIPE_LAT]),
    .wr_data ({x1_in, x2_in}),
    .pop     (out_ready),
    .rd_data ({out1, out2}),
    .valid   (out_valid),
    .count   (fifo_count)
  );

endmodule

// File: tb/tb_box_muller_ctrl.sv
// Directed bench for box_muller_ctrl with a 3-stage datapath model returning x1=issue index, x2=~index.
module tb_box_muller_ctrl;

  localparam int OUT        = 32;
  localparam int PIPE_LAT   = 3;
  localparam int FIFO_DEPTH = 8;
  localparam int CNT_W      = 16;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic             stop = 1'b0;
  logic             out_ready = 1'b0;
  logic [CNT_W-1:0] n_pairs = '0;
  logic             urng_en, rom_re, out_valid, busy, done;
  logic [OUT-1:0]   x1_in, x2_in, out1, out2;

  int total = 0;
  int bad   = 0;

  box_muller_ctrl #(
    .OUT(OUT), .PIPE_LAT(PIPE_LAT), .FIFO_DEPTH(FIFO_DEPTH), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .n_pairs(n_pairs), .stop(stop),
    .urng_en(urng_en), .rom_re(rom_re), .x1_in(x1_in), .x2_in(x2_in),
    .out1(out1), .out2(out2), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Datapath model: generator register, ROM register, product register.
  logic [31:0] idx, p1, p2, p3;
  always @(posedge clk) begin
    if (rst) idx <= '0;
    else if (urng_en) idx <= idx + 1;
    p1 <= idx;
    p2 <= p1;
    p3 <= p2;
  end
  assign x1_in = p3;
  assign x2_in = ~p3;

  int cycle = 0;
  int issue_cnt = 0, pop_cnt = 0, done_cnt = 0;
  int issue_run = 0, max_issue_run = 0, pop_run = 0, max_pop_run = 0;
  int start_cycle = 0, done_cycle = 0;
  logic [31:0] pop_q1[$];
  logic [31:0] pop_q2[$];

  always @(negedge clk) begin
    cycle = cycle + 1;
    if (rst) begin
      issue_cnt = 0; pop_cnt = 0; done_cnt = 0;
      issue_run = 0; max_issue_run = 0; pop_run = 0; max_pop_run = 0;
      pop_q1.delete();
      pop_q2.delete();
    end else begin
      if (start) start_cycle = cycle;
      if (urng_en) begin
        issue_cnt = issue_cnt + 1;
        issue_run = issue_run + 1;
        if (issue_run > max_issue_run) max_issue_run = issue_run;
      end else begin
        issue_run = 0;
      end
      if (out_valid && out_ready) begin
        pop_cnt = pop_cnt + 1;
        pop_q1.push_back(out1);
        pop_q2.push_back(out2);
        pop_run = pop_run + 1;
        if (pop_run > max_pop_run) max_pop_run = pop_run;
      end else begin
        pop_run = 0;
      end
      if (done) begin
        done_cnt   = done_cnt + 1;
        done_cycle = cycle;
      end
    end
  end

  task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total = total + 1;
    if (got !== exp) begin
      bad = bad + 1;
      $display("[TB] FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1; start = 1'b0; stop = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic apply_stimulus(input logic [CNT_W-1:0] n, input logic rdy, input logic with_stop);
    n_pairs = n; out_ready = rdy; start = 1'b1; stop = with_stop;
    tick();
    start = 1'b0; stop = 1'b0;
  endtask

  task automatic wait_done(input int limit, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < limit && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    tick();
  endtask

  task automatic check_stream(input string tag, input int n);
    logic [31:0] e, ei;
    check_output({tag, "_pops"}, pop_q1.size(), n);
    for (int i = 0; i < n && i < pop_q1.size(); i++) begin
      e  = i;
      ei = ~e;
      check_output({tag, "_x1"}, pop_q1[i], e);
      check_output({tag, "_x2"}, pop_q2[i], ei);
    end
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    bit seen;
    $display("[TB] box_muller_ctrl bench start");

    // Reset state and counted run of 5
    apply_reset();
    @(negedge clk);
    check_output("rst_urng_en", urng_en, 0);
    check_output("rst_rom_re", rom_re, 0);
    check_output("rst_out_valid", out_valid, 0);
    check_output("rst_busy", busy, 0);
    check_output("rst_done", done, 0);
    check_output("rst_out1", out1, 0);
    check_output("rst_out2", out2, 0);
    tick();
    apply_stimulus(5, 1'b1, 1'b0);
    @(negedge clk);
    check_output("t1_first_issue", urng_en, 1);
    check_output("t1_rom_re_lag", rom_re, 0);
    check_output("t1_busy", busy, 1);
    tick();
    @(negedge clk);
    check_output("t1_rom_re", rom_re, 1);
    wait_done(40, seen);
    check_output("t1_done_seen", seen, 1);
    check_output("t1_issues", issue_cnt, 5);
    check_output("t1_done_latency", done_cycle - start_cycle, 1 + 5 + PIPE_LAT + 1 + 1);
    check_output("t1_done_pulses", done_cnt, 1);
    check_stream("t1", 5);
    @(negedge clk);
    check_output("t1_idle_busy", busy, 0);
    check_output("t1_idle_done", done, 0);
    check_output("t1_idle_valid", out_valid, 0);
    tick();

    // Backpressure: 20 pairs with consumer stalled for 30 cycles
    apply_reset();
    apply_stimulus(20, 1'b0, 1'b0);
    repeat (29) tick();
    check_output("t2_credit_stop", issue_cnt, FIFO_DEPTH);
    check_output("t2_no_pops", pop_cnt, 0);
    @(negedge clk);
    check_output("t2_stall_issue", urng_en, 0);
    check_output("t2_stall_valid", out_valid, 1);
    check_output("t2_hold_out1", out1, 32'h0);
    check_output("t2_hold_out2", out2, 32'hFFFF_FFFF);
    tick();
    out_ready = 1'b1;
    @(negedge clk);
    check_output("t2_pop_not_credited", urng_en, 0);
    tick();
    @(negedge clk);
    check_output("t2_resume", urng_en, 1);
    wait_done(80, seen);
    check_output("t2_done_seen", seen, 1);
    check_output("t2_issues", issue_cnt, 20);
    check_stream("t2", 20);

    // Continuous run, stop on RUN cycle 10
    apply_reset();
    apply_stimulus(0, 1'b1, 1'b0);
    repeat (9) tick();
    stop = 1'b1;
    @(negedge clk);
    check_output("t3_stop_no_issue", urng_en, 0);
    tick();
    stop = 1'b0;
    @(negedge clk);
    check_output("t3_drain_busy", busy, 1);
    check_output("t3_drain_no_issue", urng_en, 0);
    wait_done(40, seen);
    check_output("t3_done_seen", seen, 1);
    check_output("t3_issues", issue_cnt, 9);
    check_stream("t3", 9);
    @(negedge clk);
    check_output("t3_idle_busy", busy, 0);
    tick();

    // Throughput: 100 pairs back to back
    apply_reset();
    apply_stimulus(100, 1'b1, 1'b0);
    wait_done(200, seen);
    check_output("t4_done_seen", seen, 1);
    check_output("t4_issues", issue_cnt, 100);
    check_output("t4_issue_run", max_issue_run, 100);
    check_output("t4_pop_run", max_pop_run, 100);
    check_output("t4_done_latency", done_cycle - start_cycle, 1 + 100 + PIPE_LAT + 1 + 1);
    check_stream("t4", 100);

    // Reset with 3 in flight and 4 queued, then a fresh run of 2
    apply_reset();
    apply_stimulus(20, 1'b0, 1'b0);
    repeat (7) tick();
    check_output("t5_issued_pre", issue_cnt, 7);
    rst = 1'b1;
    @(negedge clk);
    check_output("t5_valid_pre", out_valid, 1);
    tick();
    rst = 1'b0;
    @(negedge clk);
    check_output("t5_valid_post", out_valid, 0);
    check_output("t5_busy_post", busy, 0);
    check_output("t5_issue_post", urng_en, 0);
    tick();
    apply_stimulus(2, 1'b1, 1'b0);
    wait_done(40, seen);
    check_output("t5_done_seen", seen, 1);
    check_output("t5_issues", issue_cnt, 2);
    check_stream("t5", 2);

    // Start with stop in IDLE enters RUN; start during RUN is ignored
    apply_reset();
    apply_stimulus(3, 1'b1, 1'b1);
    @(negedge clk);
    check_output("t6_collision_busy", busy, 1);
    check_output("t6_collision_issue", urng_en, 1);
    tick();
    n_pairs = 10;
    start   = 1'b1;
    tick();
    start = 1'b0;
    wait_done(40, seen);
    check_output("t6_done_seen", seen, 1);
    check_output("t6_issues", issue_cnt, 3);
    check_stream("t6", 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/box_muller_ctrl.md
# box_muller_ctrl

Sequencer and output buffer for the Box-Muller Gaussian datapath. It advances both Tausworthe generators, issues the read-enable to the sqrt/ln and sin/cos ROMs, and tracks each in-flight sample through the fixed datapath latency. It captures the two multiplier products into an output FIFO and presents them to the consumer on a valid/ready handshake. Credit-based issue guarantees that no sample is ever dropped under backpressure.

## Interface
Parameters:
- OUT, 32: width of each Gaussian sample; 32 or 48.
- PIPE_LAT, 3: cycles from urng_en to products valid at x1_in/x2_in (generator register, registered ROM read, product register).
- FIFO_DEPTH, 8: output FIFO entries; power of two, at least PIPE_LAT+2.
- CNT_W, 16: width of the pair counter.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle run request; sampled only in IDLE.
- n_pairs  in  CNT_W  pairs to produce, latched on start; 0 means continuous until stop.
- stop  in  1  ends issue in RUN; level or pulse.
- urng_en  out  1  advance both Tausworthe generators this cycle (an "issue").
- rom_re  out  1  ROM read enable; urng_en delayed 1 cycle.
- x1_in  in  OUT  sin-path product from the datapath.
- x2_in  in  OUT  cos-path product from the datapath.
- out1  out  OUT  FIFO head, sin-path sample.
- out2  out  OUT  FIFO head, cos-path sample.
- out_valid  out  1  FIFO non-empty.
- out_ready  in  1  consumer accepts head when out_valid&out_ready.
- busy  out  1  state is not IDLE.
- done  out  1  one-cycle pulse in DONE.

## Operation
- Valid shift register vld[1..PIPE_LAT]:
  - vld[1] = urng_en of the previous cycle.
  - rom_re = vld[1].
  - Capture x1_in/x2_in into the FIFO in the cycle vld[PIPE_LAT]=1.
- inflight = popcount of the issues not yet captured (0..PIPE_LAT).
- Credit rule: urng_en=1 only if state=RUN and fifo_count + inflight < FIFO_DEPTH, and either the run is continuous or remaining != 0. The FIFO can therefore never overflow. A pop in the same cycle is not credited.
- remaining: loaded from n_pairs on start; decremented on each issue in counted mode.
- States:
  - IDLE: start → RUN, load remaining, clear vld. start together with stop → RUN (start wins; stop is ignored in IDLE).
  - RUN:
    - → DRAIN when stop=1; no issue in that cycle.
    - → DRAIN in counted mode when an issue makes remaining reach 0.
  - DRAIN: no issue. → DONE when inflight=0 and the FIFO is empty.
  - DONE: done=1 for one cycle, then → IDLE.
- Samples issued before stop are always delivered.
- FIFO:
  - Push and pop in the same cycle are both performed; count is unchanged.
  - A pop when empty is ignored.
  - Pointers wrap modulo FIFO_DEPTH.
  - out1/out2 are driven from the head entry (first-word fall-through).
  - out1/out2 hold their value while out_valid=1 and out_ready=0.

## Timing
- Reset (rst=1 at an edge):
  - state=IDLE; vld, remaining, pointers and count cleared.
  - urng_en, rom_re, out_valid, busy, done = 0; out1/out2 = 0.
  - In-flight samples are discarded. Reset mid-run has the same effect.
- start at edge t: RUN from t+1; first urng_en at cycle t+1 (registered decision).
- Issue at cycle k: rom_re at k+1, capture at k+PIPE_LAT, out_valid at k+PIPE_LAT+1.
- Throughput: 1 pair/cycle sustained with out_ready held high.
- Counted run of N pairs, never stalled: done at 1 + N + PIPE_LAT + 1 + 1 cycles after start, once the final pop has occurred.
- Backpressure, out_ready=0: issue stops after FIFO_DEPTH outstanding samples. Issue resumes the cycle after the first pop frees credit.

## Structure
- Package box_muller_pkg holds:
  - state enum (IDLE, RUN, DRAIN, DONE);
  - default PIPE_LAT and FIFO_DEPTH;
  - $clog2-based count-width constants shared with the top level.
- One sub-module: bm_out_fifo, a synchronous FWFT FIFO of width 2*OUT with count output.
- Controller FSM, credit logic and vld shift register live in box_muller_ctrl.

## Test plan
- Counted run:
  - Stimulus: n_pairs=5, out_ready=1, datapath model returning x1=issue index, x2=~index.
  - Required: exactly 5 urng_en pulses; outputs in order 0..4; done pulse after the last pop; busy then 0.
- Backpressure:
  - Stimulus: n_pairs=20, out_ready=0 for 30 cycles, then 1.
  - Required: urng_en stops after 8 issues; no loss or duplication; all 20 values delivered in order.
- Continuous plus stop:
  - Stimulus: n_pairs=0, stop asserted on cycle 10 of RUN.
  - Required: no issue from the stop cycle on; every prior issue delivered; then DONE and IDLE.
- Throughput:
  - Stimulus: n_pairs=100, out_ready=1.
  - Required: urng_en high on 100 consecutive cycles; 100 pops on consecutive cycles.
- Reset mid-run:
  - Stimulus: rst during RUN with 3 in flight and 4 in the FIFO.
  - Required: next cycle out_valid=0, busy=0, urng_en=0; a fresh start with n_pairs=2 yields exactly 2 outputs.
- Start/stop collision:
  - Stimulus: start and stop together in IDLE; later, start pulsed during RUN.
  - Required: the first enters RUN; the second is ignored (remaining unchanged).
